// File: rtl/sa_result_writer.sv
// ---------------------------------------------------------------------------
// sa_result_writer
//
// Sink side of the systolic tile-output stream. Quantized int8 result rows
// (N bytes each) arrive one per active in_wen_n cycle. Each row's
// tile-local index is remapped to a global row-major word address. The row
// is buffered in a small FIFO and written to the result SRAM as one 64-bit
// word whenever the SRAM port is granted. done pulses once after the final
// word of a job has landed.
//
// Parameters
//   N        array dimension; bytes per row word (N*8 must equal 64)
//   FIFO_D   buffer depth in rows (power of two, >= 2)
//
// Optional build macro
//   SA_RESULT_RELU_EN  when defined, each byte is treated as signed int8 and
//                      negative bytes are written as 8'h00 (applied at push).
//                      When undefined, bytes pass through unchanged.
//
// Ports
//   clk          in   1     clock
//   rst_n        in   1     asynchronous active-low reset
//   start        in   1     1-cycle pulse that begins a job (IDLE only)
//   row_shape    in   8     row tiles; rows per job = N*row_shape (>= 1)
//   col_shape    in   8     col tiles; 64-bit words per output row (>= 1)
//   in_wen_n     in   1     active-low: in_data/in_waddr valid this cycle
//   in_waddr     in   12    tile-local row index (low $clog2(N) bits used)
//   in_data      in   N*8   result row, byte i = tile column i
//   sram_ready   in   1     SRAM port granted this cycle
//   sram_wen_n   out  1     active-low write strobe (registered)
//   sram_waddr   out  12    global word address (registered)
//   sram_wdata   out  64    write data (registered)
//   busy         out  1     high while the job is in RUN or FLUSH
//   done         out  1     1-cycle pulse after the final SRAM write
//   err          out  2     sticky: [0] overflow, [1] row-order mismatch
//
// Handshake semantics
//   Input side: a row is offered whenever in_wen_n=0. There is no ready
//   back to the producer; rows offered while the FIFO is full (and nothing
//   pops that cycle) are dropped and flagged in err[0]. Rows offered
//   outside RUN are silently ignored.
//   SRAM side: when the FIFO holds a row and sram_ready=1 in a cycle, that
//   row is popped at the clock edge and presented on the registered
//   sram_* outputs with sram_wen_n=0 for the following cycle. With
//   sram_ready=0 the FIFO holds and sram_wen_n is 1 the following cycle.
// ---------------------------------------------------------------------------
module sa_result_writer #(
    parameter int N      = 8,
    parameter int FIFO_D = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       row_shape,
    input  logic [7:0]       col_shape,
    input  logic             in_wen_n,
    input  logic [11:0]      in_waddr,
    input  logic [N*8-1:0]   in_data,
    input  logic             sram_ready,
    output logic             sram_wen_n,
    output logic [11:0]      sram_waddr,
    output logic [63:0]      sram_wdata,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err
);

    localparam int DW = N * 8;
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t          state_q;
    logic [RW-1:0]   r_q;          // row within the current tile
    logic [7:0]      col_t_q;      // column tile index
    logic [7:0]      row_t_q;      // row tile index
    logic [1:0]      err_q;
    logic            busy_q;
    logic            done_q;

    // FIFO storage: address and data travel together
    logic [11:0]     addr_mem [FIFO_D];
    logic [DW-1:0]   data_mem [FIFO_D];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // Registered SRAM write port
    logic            wen_n_q;
    logic [11:0]     waddr_q;
    logic [DW-1:0]   wdata_q;

    // -----------------------------------------------------------------------
    // Combinational control
    // -----------------------------------------------------------------------
    logic            in_valid;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            push;
    logic            overflow;
    logic            order_err;
    logic            r_last;
    logic            col_last;
    logic            row_last;
    logic            last_row;

    logic [RW-1:0]   r_d;
    logic [7:0]      col_t_d;
    logic [7:0]      row_t_d;

    logic [19:0]     grow;         // global row = row_t*N + r
    logic [11:0]     push_addr;
    logic [DW-1:0]   push_data;

    // Upper in_waddr bits carry no meaning here; folded into a named sink.
    logic            unused_waddr_bits;
    assign unused_waddr_bits = ^in_waddr[11:RW];

    assign in_valid   = (state_q == S_RUN) && !in_wen_n;
    assign fifo_full  = (count_q == CW'(FIFO_D));
    assign fifo_empty = (count_q == '0);

    // The pop decision is independent of the push, so a full FIFO that is
    // draining this cycle still accepts the incoming row.
    assign pop        = !fifo_empty && sram_ready;
    assign push       = in_valid && (!fifo_full || pop);
    assign overflow   = in_valid && fifo_full && !pop;
    assign order_err  = in_valid && (in_waddr[RW-1:0] != r_q);

    assign r_last     = (r_q == RW'(N - 1));
    assign col_last   = (col_t_q == (col_shape - 8'd1));
    assign row_last   = (row_t_q == (row_shape - 8'd1));
    assign last_row   = in_valid && r_last && col_last && row_last;

    // Tile counters: r runs fastest, then column tile, then row tile.
    always_comb begin
        r_d     = r_q + RW'(1);
        col_t_d = col_t_q;
        row_t_d = row_t_q;
        if (r_last) begin
            r_d = '0;
            if (col_last) begin
                col_t_d = '0;
                row_t_d = row_t_q + 8'd1;
            end else begin
                col_t_d = col_t_q + 8'd1;
            end
        end
    end

    // Global row-major word address, wrapped into the 12-bit SRAM space.
    always_comb begin
        grow      = 20'(row_t_q) * 20'(N) + 20'(r_q);
        push_addr = 12'(grow * 20'(col_shape) + 20'(col_t_q));
    end

    // Byte lanes keep their order: byte i of in_data lands in bits 8i+7:8i.
    always_comb begin
        push_data = in_data;
`ifdef SA_RESULT_RELU_EN
        for (int i = 0; i < N; i++) begin
            if (in_data[8*i+7]) begin
                push_data[8*i +: 8] = 8'h00;
            end
        end
`endif
    end

    // -----------------------------------------------------------------------
    // FIFO storage (no reset needed: occupancy is tracked by count_q)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= push_addr;
            data_mem[wr_ptr_q] <= push_data;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and registered SRAM port
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wen_n_q  <= 1'b1;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase

            wen_n_q <= !pop;
            if (pop) begin
                waddr_q <= addr_mem[rd_ptr_q];
                wdata_q <= data_mem[rd_ptr_q];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Job FSM with registered busy/done/err
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            col_t_q <= '0;
            row_t_q <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        r_q     <= '0;
                        col_t_q <= '0;
                        row_t_q <= '0;
                        err_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Counters advance on every offered row, dropped or not,
                    // so the job length is fixed by the shape alone.
                    if (in_valid) begin
                        r_q     <= r_d;
                        col_t_q <= col_t_d;
                        row_t_q <= row_t_d;
                        err_q   <= err_q | {order_err, overflow};
                        if (last_row) begin
                            state_q <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // Wait until the buffer is drained and the last strobe
                    // has left the output register.
                    if (fifo_empty && wen_n_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign sram_wen_n = wen_n_q;
    assign sram_waddr = waddr_q;
    assign sram_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sa_result_writer.sv
// ---------------------------------------------------------------------------
// tb_sa_result_writer
//
// Directed bench for sa_result_writer. A queue-level model derives, from the
// row index of every accepted row, the tile coordinates, the global address,
// the FIFO admission decision and the expected SRAM write for each cycle.
// A single compare process checks the write port and err every cycle;
// directed jobs add literal expectations for addresses, data and flags.
// ---------------------------------------------------------------------------
module tb_sa_result_writer;

    localparam int N      = 8;
    localparam int FIFO_D = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  row_shape;
    logic [7:0]  col_shape;
    logic        in_wen_n;
    logic [11:0] in_waddr;
    logic [63:0] in_data;
    logic        sram_ready;
    logic        sram_wen_n;
    logic [11:0] sram_waddr;
    logic [63:0] sram_wdata;
    logic        busy;
    logic        done;
    logic [1:0]  err;

    sa_result_writer #(.N(N), .FIFO_D(FIFO_D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .row_shape  (row_shape),
        .col_shape  (col_shape),
        .in_wen_n   (in_wen_n),
        .in_waddr   (in_waddr),
        .in_data    (in_data),
        .sram_ready (sram_ready),
        .sram_wen_n (sram_wen_n),
        .sram_waddr (sram_waddr),
        .sram_wdata (sram_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // -----------------------------------------------------------------------
    // Clock / cycle counter
    // -----------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // -----------------------------------------------------------------------
    // Model
    // -----------------------------------------------------------------------
    logic [75:0] exp_q[$];      // rows buffered in front of the SRAM
    logic [75:0] m_ent;
    int          m_state;       // 0 idle, 1 accepting rows, 2 draining
    int          m_idx, m_tot, m_cs;
    int          m_r, m_c, m_row, m_a;
    logic [1:0]  m_err;
    logic        exp_valid;
    logic [11:0] exp_addr;
    logic [63:0] exp_data;

    function automatic logic [63:0] relu(input logic [63:0] d);
        logic [63:0] o;
        o = d;
`ifdef SA_RESULT_RELU_EN
        for (int i = 0; i < 8; i++) begin
            if ($signed(d[8*i +: 8]) < 0) o[8*i +: 8] = 8'h00;
        end
`endif
        return o;
    endfunction

    initial begin
        m_state   = 0;
        m_err     = 2'b00;
        exp_valid = 1'b0;
        exp_addr  = '0;
        exp_data  = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                m_state   = 0;
                m_err     = 2'b00;
                exp_valid = 1'b0;
            end else begin
                // A granted cycle moves the oldest buffered row to the port.
                exp_valid = 1'b0;
                if (exp_q.size() > 0 && sram_ready) begin
                    m_ent     = exp_q.pop_front();
                    exp_valid = 1'b1;
                    exp_addr  = m_ent[75:64];
                    exp_data  = m_ent[63:0];
                end
                case (m_state)
                    0: begin
                        if (start) begin
                            m_state = 1;
                            m_idx   = 0;
                            m_err   = 2'b00;
                            m_cs    = int'(col_shape);
                            m_tot   = N * int'(row_shape) * m_cs;
                        end
                    end
                    1: begin
                        if (!in_wen_n) begin
                            m_r   = m_idx % N;
                            m_c   = (m_idx / N) % m_cs;
                            m_row = m_idx / (N * m_cs);
                            m_a   = ((m_row * N + m_r) * m_cs + m_c) % 4096;
                            if (int'(in_waddr[2:0]) != m_r) m_err[1] = 1'b1;
                            if (exp_q.size() < FIFO_D)
                                exp_q.push_back({12'(m_a), relu(in_data)});
                            else
                                m_err[0] = 1'b1;
                            m_idx++;
                            if (m_idx == m_tot) m_state = 2;
                        end
                    end
                    2: begin
                        if (exp_q.size() == 0 && !exp_valid) m_state = 0;
                    end
                    default: m_state = 0;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Compare process (negedge, away from the active edge)
    // -----------------------------------------------------------------------
    logic [75:0] wr_log[$];
    int          wr_cnt      = 0;
    int          done_cnt    = 0;
    int          last_wr_cyc = -100;
    bit          chk_en      = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("wen_n", 64'(sram_wen_n), 64'(!exp_valid));
                if (exp_valid && !sram_wen_n) begin
                    check("waddr", 64'(sram_waddr), 64'(exp_addr));
                    check("wdata", sram_wdata, exp_data);
                end
                check("err", 64'(err), 64'(m_err));
                if (!sram_wen_n) begin
                    wr_log.push_back({sram_waddr, sram_wdata});
                    wr_cnt++;
                    last_wr_cyc = cyc;
                end
                if (done) begin
                    done_cnt++;
                    check("done_latency", 64'(cyc), 64'(last_wr_cyc + 2));
                    check("busy_at_done", 64'(busy), 64'd0);
                end
            end
        end
    end

    function automatic logic [63:0] log_addr(input int k);
        if (k < wr_log.size()) return 64'(wr_log[k][75:64]);
        return 64'hFFFF_FFFF;
    endfunction

    function automatic logic [63:0] log_data(input int k);
        if (k < wr_log.size()) return wr_log[k][63:0];
        return 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    int wr_base;
    int done_base;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] rs, input logic [7:0] cs);
        row_shape = rs;
        col_shape = cs;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_row(input logic [11:0] a, input logic [63:0] d);
        in_wen_n = 1'b0;
        in_waddr = a;
        in_data  = d;
        tick();
        in_wen_n = 1'b1;
    endtask

    task automatic job_begin();
        wr_log.delete();
        wr_base   = wr_cnt;
        done_base = done_cnt;
    endtask

    task automatic wait_done();
        int t;
        int base;
        t    = 0;
        base = done_cnt;
        while (done_cnt == base && t < 300) begin
            tick();
            t++;
        end
        if (done_cnt == base) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_done: no done pulse within %0d cycles", t);
        end
        repeat (4) tick();
    endtask

    task automatic job_end(input int exp_wr, input logic [1:0] exp_err);
        check("write_count", 64'(wr_cnt - wr_base), 64'(exp_wr));
        check("done_count", 64'(done_cnt - done_base), 64'd1);
        check("err_final", 64'(err), 64'(exp_err));
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        row_shape  = 8'd1;
        col_shape  = 8'd1;
        in_wen_n   = 1'b1;
        in_waddr   = '0;
        in_data    = '0;
        sram_ready = 1'b1;
        repeat (2) tick();

        // Reset values
        check("rst_wen_n", 64'(sram_wen_n), 64'd1);
        check("rst_waddr", 64'(sram_waddr), 64'd0);
        check("rst_wdata", sram_wdata, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);

        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // A row offered in IDLE is ignored
        send_row(12'd0, 64'hDEAD_BEEF_0000_0001);
        repeat (3) tick();
        check("idle_busy", 64'(busy), 64'd0);

        // Job 1: single tile, rows r*0x0101..01 -> addresses 0..7
        job_begin();
        do_start(8'd1, 8'd1);
        check("busy_run", 64'(busy), 64'd1);
        for (int i = 0; i < 8; i++)
            send_row(12'(i), 64'(i) * 64'h0101_0101_0101_0101);
        wait_done();
        job_end(8, 2'b00);
        check("j1_addr7", log_addr(7), 64'd7);
        check("j1_data7", log_data(7), 64'h0707_0707_0707_0707);

        // Job 2: 2x3 tiles with input gaps and a start pulse during RUN
        job_begin();
        do_start(8'd2, 8'd3);
        for (int i = 0; i < 48; i++) begin
            if (i % 5 == 4) tick();
            if (i == 20) start = 1'b1;
            send_row(12'(i % 8), {8{8'(i)}});
            start = 1'b0;
        end
        wait_done();
        job_end(48, 2'b00);
        check("j2_addr8", log_addr(8), 64'd1);
        check("j2_addr45", log_addr(45), 64'd41);
        check("j2_data45", log_data(45), 64'h2D2D_2D2D_2D2D_2D2D);
        check("j2_addr47", log_addr(47), 64'd47);

        // Job 3: SRAM stalled for 10 cycles while 8 rows arrive -> overflow
        sram_ready = 1'b0;
        job_begin();
        do_start(8'd1, 8'd1);
        for (int i = 0; i < 8; i++)
            send_row(12'(i), {8{8'(i + 16)}});
        repeat (2) tick();
        check("j3_err_overflow", 64'(err), 64'd1);
        sram_ready = 1'b1;
        wait_done();
        job_end(4, 2'b01);
        check("j3_addr3", log_addr(3), 64'd3);
        check("j3_data3", log_data(3), 64'h1313_1313_1313_1313);

        // Job 4: FIFO fills, then push and pop coincide on a full FIFO
        sram_ready = 1'b0;
        job_begin();
        do_start(8'd1, 8'd1);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) sram_ready = 1'b1;
            send_row(12'(i), {8{8'(i + 32)}});
        end
        wait_done();
        job_end(8, 2'b00);
        check("j4_data7", log_data(7), 64'h2727_2727_2727_2727);

        // Job 5: in_waddr 0,1,3 -> order error on the third row
        job_begin();
        do_start(8'd1, 8'd1);
        send_row(12'd0, {8{8'h20}});
        send_row(12'd1, {8{8'h21}});
        check("j5_err_clean", 64'(err), 64'd0);
        send_row(12'd3, {8{8'h22}});
        check("j5_err_order", 64'(err), 64'd2);
        for (int i = 3; i < 8; i++)
            send_row(12'(i), {8{8'(i + 32)}});
        wait_done();
        job_end(8, 2'b10);
        check("j5_addr2", log_addr(2), 64'd2);
        check("j5_data2", log_data(2), 64'h2222_2222_2222_2222);

        // Job 6: asynchronous reset mid-RUN, then a clean restart
        job_begin();
        do_start(8'd1, 8'd1);
        send_row(12'd0, {8{8'h50}});
        send_row(12'd5, {8{8'h51}});
        send_row(12'd2, {8{8'h52}});
        check("j6_err_pre", 64'(err), 64'd2);
        check("j6_wen_pre", 64'(sram_wen_n), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("j6_rst_wen_n", 64'(sram_wen_n), 64'd1);
        check("j6_rst_busy", 64'(busy), 64'd0);
        check("j6_rst_err", 64'(err), 64'd0);
        check("j6_rst_done", 64'(done), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("j6_no_done", 64'(done_cnt - done_base), 64'd0);
        job_begin();
        do_start(8'd1, 8'd1);
        for (int i = 0; i < 8; i++)
            send_row(12'(i), {8{8'(i + 96)}});
        wait_done();
        job_end(8, 2'b00);
        check("j6_addr0", log_addr(0), 64'd0);
        check("j6_data0", log_data(0), 64'h6060_6060_6060_6060);

        // Job 7: signed bytes 0x80,0x7F,0xFF,0x01,... in lane order
        job_begin();
        do_start(8'd1, 8'd1);
        send_row(12'd0, 64'h7E00_C040_01FF_7F80);
        for (int i = 1; i < 8; i++)
            send_row(12'(i), 64'(i) * 64'h0101_0101_0101_0101);
        wait_done();
        job_end(8, 2'b00);
`ifdef SA_RESULT_RELU_EN
        check("j7_data0", log_data(0), 64'h7E00_0040_0100_7F00);
`else
        check("j7_data0", log_data(0), 64'h7E00_C040_01FF_7F80);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
